// File: rtl/agc_chan_pkg.sv
// Shared constants for the AGC inout VI channel registers: widths, bit positions, channel addresses.
package agc_chan_pkg;

    localparam int unsigned CH05_W = 8;
    localparam int unsigned CH06_W = 8;
    localparam int unsigned CH11_W = 7;
    localparam int unsigned CH12_W = 14;
    localparam int unsigned CHOR_W = 8;
    localparam int unsigned CHWL_W = 14;

    localparam logic [5:0] CH_ADDR_05 = 6'o05;
    localparam logic [5:0] CH_ADDR_06 = 6'o06;
    localparam logic [5:0] CH_ADDR_11 = 6'o11;
    localparam logic [5:0] CH_ADDR_12 = 6'o12;

    // Jet bit positions (1-based), shared layout for channels 05 and 06
    localparam int unsigned JET_B1 = 1;
    localparam int unsigned JET_B2 = 2;
    localparam int unsigned JET_B3 = 3;
    localparam int unsigned JET_B4 = 4;
    localparam int unsigned JET_B5 = 5;
    localparam int unsigned JET_B6 = 6;
    localparam int unsigned JET_B7 = 7;
    localparam int unsigned JET_B8 = 8;

    localparam int unsigned CH11_ISSWAR = 1;
    localparam int unsigned CH11_COMACT = 2;
    localparam int unsigned CH11_UPLACT = 3;
    localparam int unsigned CH11_TMPOUT = 4;
    localparam int unsigned CH11_KYRLS  = 5;
    localparam int unsigned CH11_VNFLSH = 6;
    localparam int unsigned CH11_OPEROR = 7;

    localparam int unsigned CH12_ZOPCDU = 1;
    localparam int unsigned CH12_ENEROP = 2;
    localparam int unsigned CH12_STARON = 3;
    localparam int unsigned CH12_COARSE = 4;
    localparam int unsigned CH12_ZIMCDU = 5;
    localparam int unsigned CH12_ENERIM = 6;
    localparam int unsigned CH12_B7     = 7;
    localparam int unsigned CH12_TVCNAB = 8;
    localparam int unsigned CH12_S4BTAK = 9;
    localparam int unsigned CH12_ZEROPT = 10;
    localparam int unsigned CH12_DISDAC = 11;
    localparam int unsigned CH12_MROLGT = 12;
    localparam int unsigned CH12_S4BSEQ = 13;
    localparam int unsigned CH12_S4BOFF = 14;

    // Channel select from a pair of active-low XT/XB decode lines
    function automatic logic chan_sel(input logic xt_n, input logic xb_n);
        return !xt_n && !xb_n;
    endfunction

endpackage

// File: rtl/agc_chan_reg.sv
// One output channel register: reset/GOJAM clears, then write (inverted bus data), then clear.
module agc_chan_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gojam,
    input  logic         wr,
    input  logic         clr,
    input  logic [W-1:0] data_n,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Write wins over a simultaneous clear; restart beats both
    always_ff @(posedge clk) begin
        if (rst || gojam) begin
            r_q <= '0;
        end else if (wr) begin
            r_q <= ~data_n;
        end else if (clr) begin
            r_q <= '0;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/a16_inout_vi.sv
// AGC Block II inout module VI: channels 05/06 (RCS jets), 11 bits 1-7 (lamps), 12 bits 1-14,
// plus channel strobe decode and the active-low read bus contribution CHOR01_..CHOR08_.
module a16_inout_vi
    import agc_chan_pkg::*;
(
    input  logic CLOCK,
    input  logic rst,
    input  logic XT0_, XT1_, XB2_, XB5_, XB6_,
    input  logic WCHG_, CCHG_,
    input  logic WCH11_, RCH11_,
    input  logic CCH11,
    input  logic CHWL01_, CHWL02_, CHWL03_, CHWL04_, CHWL05_, CHWL06_, CHWL07_,
    input  logic CHWL08_, CHWL09_, CHWL10_, CHWL11_, CHWL12_, CHWL13_, CHWL14_,
    input  logic GOJAM,
    input  logic FLASH, FLASH_,
    input  logic CH0705, CH0706, CH0707,
    input  logic CH1501, CH1502, CH1503, CH1504,
    input  logic CH3201, CH3202, CH3203, CH3204, CH3205, CH3206, CH3207, CH3208,
    input  logic CGA16,
    output logic RCH05_, WCH05_, RCH06_, WCH06_, RCH12_, WCH12_,
    output logic CCH05, CCH06, CCH12,
    output logic CHOR01_, CHOR02_, CHOR03_, CHOR04_, CHOR05_, CHOR06_, CHOR07_, CHOR08_,
    output logic RCpXpP, RCmXmP, RCpXmP, RCmXpP, RCpXpY, RCmXmY, RCpXmY, RCmXpY,
    output logic RCpYpR, RCmYmR, RCpYmR, RCmYpR, RCpZpR, RCmZmR, RCpZmR, RCmZpR,
    output logic ISSWAR, COMACT, UPLACT, TMPOUT, KYRLS, VNFLSH, OPEROR,
    output logic ZOPCDU, ENEROP, STARON, COARSE, ZIMCDU, ENERIM,
    output logic CH1207, OT1207, OT1207_,
    output logic CH1208, CH1209, CH1210, CH1211, CH1212, CH1213, CH1214,
    output logic TVCNAB, S4BTAK, ZEROPT, DISDAC, MROLGT, S4BSEQ, S4BOFF
);

    logic              w_a05, w_a06, w_a12;
    logic [CHWL_W:1]   w_chwl_n;
    logic [CH05_W:1]   r_ch05;
    logic [CH06_W:1]   r_ch06;
    logic [CH11_W:1]   r_ch11;
    logic [CH12_W:1]   r_ch12;
    logic [CHOR_W:1]   w_chor;
    logic              w_unused_cga16;

    assign w_unused_cga16 = CGA16;

    assign w_a05 = chan_sel(XT0_, XB5_);
    assign w_a06 = chan_sel(XT0_, XB6_);
    assign w_a12 = chan_sel(XT1_, XB2_);

    assign RCH05_ = !w_a05;
    assign WCH05_ = !(w_a05 && !WCHG_);
    assign CCH05  = w_a05 && !CCHG_;
    assign RCH06_ = !w_a06;
    assign WCH06_ = !(w_a06 && !WCHG_);
    assign CCH06  = w_a06 && !CCHG_;
    assign RCH12_ = !w_a12;
    assign WCH12_ = !(w_a12 && !WCHG_);
    assign CCH12  = w_a12 && !CCHG_;

    assign w_chwl_n = {CHWL14_, CHWL13_, CHWL12_, CHWL11_, CHWL10_, CHWL09_, CHWL08_,
                       CHWL07_, CHWL06_, CHWL05_, CHWL04_, CHWL03_, CHWL02_, CHWL01_};

    agc_chan_reg #(.W(CH05_W)) u_ch05 (
        .clk(CLOCK), .rst(rst), .gojam(GOJAM), .wr(!WCH05_), .clr(CCH05),
        .data_n(w_chwl_n[CH05_W:1]), .q(r_ch05)
    );

    agc_chan_reg #(.W(CH06_W)) u_ch06 (
        .clk(CLOCK), .rst(rst), .gojam(GOJAM), .wr(!WCH06_), .clr(CCH06),
        .data_n(w_chwl_n[CH06_W:1]), .q(r_ch06)
    );

    agc_chan_reg #(.W(CH11_W)) u_ch11 (
        .clk(CLOCK), .rst(rst), .gojam(GOJAM), .wr(!WCH11_), .clr(CCH11),
        .data_n(w_chwl_n[CH11_W:1]), .q(r_ch11)
    );

    agc_chan_reg #(.W(CH12_W)) u_ch12 (
        .clk(CLOCK), .rst(rst), .gojam(GOJAM), .wr(!WCH12_), .clr(CCH12),
        .data_n(w_chwl_n[CH12_W:1]), .q(r_ch12)
    );

    assign RCpXpP = r_ch05[JET_B1];
    assign RCmXmP = r_ch05[JET_B2];
    assign RCpXmP = r_ch05[JET_B3];
    assign RCmXpP = r_ch05[JET_B4];
    assign RCpXpY = r_ch05[JET_B5];
    assign RCmXmY = r_ch05[JET_B6];
    assign RCpXmY = r_ch05[JET_B7];
    assign RCmXpY = r_ch05[JET_B8];

    assign RCpYpR = r_ch06[JET_B1];
    assign RCmYmR = r_ch06[JET_B2];
    assign RCpYmR = r_ch06[JET_B3];
    assign RCmYpR = r_ch06[JET_B4];
    assign RCpZpR = r_ch06[JET_B5];
    assign RCmZmR = r_ch06[JET_B6];
    assign RCpZmR = r_ch06[JET_B7];
    assign RCmZpR = r_ch06[JET_B8];

    // Key-release and operator-error lamps flash in phase, verb/noun in antiphase
    assign ISSWAR = r_ch11[CH11_ISSWAR];
    assign COMACT = r_ch11[CH11_COMACT];
    assign UPLACT = r_ch11[CH11_UPLACT];
    assign TMPOUT = r_ch11[CH11_TMPOUT];
    assign KYRLS  = r_ch11[CH11_KYRLS]  && FLASH;
    assign VNFLSH = r_ch11[CH11_VNFLSH] && FLASH_;
    assign OPEROR = r_ch11[CH11_OPEROR] && FLASH;

    assign ZOPCDU  = r_ch12[CH12_ZOPCDU];
    assign ENEROP  = r_ch12[CH12_ENEROP];
    assign STARON  = r_ch12[CH12_STARON];
    assign COARSE  = r_ch12[CH12_COARSE];
    assign ZIMCDU  = r_ch12[CH12_ZIMCDU];
    assign ENERIM  = r_ch12[CH12_ENERIM];
    assign CH1207  = r_ch12[CH12_B7];
    assign OT1207  = r_ch12[CH12_B7];
    assign OT1207_ = !r_ch12[CH12_B7];
    assign CH1208  = r_ch12[CH12_TVCNAB];
    assign CH1209  = r_ch12[CH12_S4BTAK];
    assign CH1210  = r_ch12[CH12_ZEROPT];
    assign CH1211  = r_ch12[CH12_DISDAC];
    assign CH1212  = r_ch12[CH12_MROLGT];
    assign CH1213  = r_ch12[CH12_S4BSEQ];
    assign CH1214  = r_ch12[CH12_S4BOFF];
    assign TVCNAB  = r_ch12[CH12_TVCNAB];
    assign S4BTAK  = r_ch12[CH12_S4BTAK];
    assign ZEROPT  = r_ch12[CH12_ZEROPT];
    assign DISDAC  = r_ch12[CH12_DISDAC];
    assign MROLGT  = r_ch12[CH12_MROLGT];
    assign S4BSEQ  = r_ch12[CH12_S4BSEQ];
    assign S4BOFF  = r_ch12[CH12_S4BOFF];

    // Read bus: wired-OR of every read-gated source, driven active low; ch12 bits 9-14 never read here
    assign w_chor = ({CHOR_W{!RCH05_}} & r_ch05)
                  | ({CHOR_W{!RCH06_}} & r_ch06)
                  | ({CHOR_W{!RCH11_}} & {1'b0, r_ch11})
                  | ({CHOR_W{!RCH12_}} & r_ch12[CHOR_W:1])
                  | {4'b0000, CH1504, CH1503, CH1502, CH1501}
                  | {1'b0, CH0707, CH0706, CH0705, 4'b0000}
                  | {CH3208, CH3207, CH3206, CH3205, CH3204, CH3203, CH3202, CH3201};

    assign {CHOR08_, CHOR07_, CHOR06_, CHOR05_, CHOR04_, CHOR03_, CHOR02_, CHOR01_} = ~w_chor;

endmodule

// File: tb/tb_a16_inout_vi.sv
// Scoreboard bench for a16_inout_vi: directed stimulus queues expected values, a negedge monitor checks them.
module tb_a16_inout_vi;

    logic CLOCK, rst;
    logic XT0_, XT1_, XB2_, XB5_, XB6_;
    logic WCHG_, CCHG_, WCH11_, RCH11_, CCH11;
    logic [13:0] chwl_n;
    logic GOJAM, FLASH, FLASH_;
    logic CH0705, CH0706, CH0707;
    logic CH1501, CH1502, CH1503, CH1504;
    logic [7:0] ch32;
    logic CGA16;

    logic RCH05_, WCH05_, RCH06_, WCH06_, RCH12_, WCH12_, CCH05, CCH06, CCH12;
    logic CHOR01_, CHOR02_, CHOR03_, CHOR04_, CHOR05_, CHOR06_, CHOR07_, CHOR08_;
    logic RCpXpP, RCmXmP, RCpXmP, RCmXpP, RCpXpY, RCmXmY, RCpXmY, RCmXpY;
    logic RCpYpR, RCmYmR, RCpYmR, RCmYpR, RCpZpR, RCmZmR, RCpZmR, RCmZpR;
    logic ISSWAR, COMACT, UPLACT, TMPOUT, KYRLS, VNFLSH, OPEROR;
    logic ZOPCDU, ENEROP, STARON, COARSE, ZIMCDU, ENERIM;
    logic CH1207, OT1207, OT1207_;
    logic CH1208, CH1209, CH1210, CH1211, CH1212, CH1213, CH1214;
    logic TVCNAB, S4BTAK, ZEROPT, DISDAC, MROLGT, S4BSEQ, S4BOFF;

    a16_inout_vi dut (
        .CLOCK(CLOCK), .rst(rst),
        .XT0_(XT0_), .XT1_(XT1_), .XB2_(XB2_), .XB5_(XB5_), .XB6_(XB6_),
        .WCHG_(WCHG_), .CCHG_(CCHG_), .WCH11_(WCH11_), .RCH11_(RCH11_), .CCH11(CCH11),
        .CHWL01_(chwl_n[0]), .CHWL02_(chwl_n[1]), .CHWL03_(chwl_n[2]), .CHWL04_(chwl_n[3]),
        .CHWL05_(chwl_n[4]), .CHWL06_(chwl_n[5]), .CHWL07_(chwl_n[6]), .CHWL08_(chwl_n[7]),
        .CHWL09_(chwl_n[8]), .CHWL10_(chwl_n[9]), .CHWL11_(chwl_n[10]), .CHWL12_(chwl_n[11]),
        .CHWL13_(chwl_n[12]), .CHWL14_(chwl_n[13]),
        .GOJAM(GOJAM), .FLASH(FLASH), .FLASH_(FLASH_),
        .CH0705(CH0705), .CH0706(CH0706), .CH0707(CH0707),
        .CH1501(CH1501), .CH1502(CH1502), .CH1503(CH1503), .CH1504(CH1504),
        .CH3201(ch32[0]), .CH3202(ch32[1]), .CH3203(ch32[2]), .CH3204(ch32[3]),
        .CH3205(ch32[4]), .CH3206(ch32[5]), .CH3207(ch32[6]), .CH3208(ch32[7]),
        .CGA16(CGA16),
        .RCH05_(RCH05_), .WCH05_(WCH05_), .RCH06_(RCH06_), .WCH06_(WCH06_),
        .RCH12_(RCH12_), .WCH12_(WCH12_), .CCH05(CCH05), .CCH06(CCH06), .CCH12(CCH12),
        .CHOR01_(CHOR01_), .CHOR02_(CHOR02_), .CHOR03_(CHOR03_), .CHOR04_(CHOR04_),
        .CHOR05_(CHOR05_), .CHOR06_(CHOR06_), .CHOR07_(CHOR07_), .CHOR08_(CHOR08_),
        .RCpXpP(RCpXpP), .RCmXmP(RCmXmP), .RCpXmP(RCpXmP), .RCmXpP(RCmXpP),
        .RCpXpY(RCpXpY), .RCmXmY(RCmXmY), .RCpXmY(RCpXmY), .RCmXpY(RCmXpY),
        .RCpYpR(RCpYpR), .RCmYmR(RCmYmR), .RCpYmR(RCpYmR), .RCmYpR(RCmYpR),
        .RCpZpR(RCpZpR), .RCmZmR(RCmZmR), .RCpZmR(RCpZmR), .RCmZpR(RCmZpR),
        .ISSWAR(ISSWAR), .COMACT(COMACT), .UPLACT(UPLACT), .TMPOUT(TMPOUT),
        .KYRLS(KYRLS), .VNFLSH(VNFLSH), .OPEROR(OPEROR),
        .ZOPCDU(ZOPCDU), .ENEROP(ENEROP), .STARON(STARON), .COARSE(COARSE),
        .ZIMCDU(ZIMCDU), .ENERIM(ENERIM),
        .CH1207(CH1207), .OT1207(OT1207), .OT1207_(OT1207_),
        .CH1208(CH1208), .CH1209(CH1209), .CH1210(CH1210), .CH1211(CH1211),
        .CH1212(CH1212), .CH1213(CH1213), .CH1214(CH1214),
        .TVCNAB(TVCNAB), .S4BTAK(S4BTAK), .ZEROPT(ZEROPT), .DISDAC(DISDAC),
        .MROLGT(MROLGT), .S4BSEQ(S4BSEQ), .S4BOFF(S4BOFF)
    );

    localparam int SEL_JET05 = 0;
    localparam int SEL_JET06 = 1;
    localparam int SEL_CH11  = 2;
    localparam int SEL_CH12  = 3;
    localparam int SEL_NAMED = 4;
    localparam int SEL_CHOR  = 5;
    localparam int SEL_STRB  = 6;

    typedef struct {
        int          sel;
        logic [15:0] expv;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SEL_JET05: return 16'({RCmXpY, RCpXmY, RCmXmY, RCpXpY, RCmXpP, RCpXmP, RCmXmP, RCpXpP});
            SEL_JET06: return 16'({RCmZpR, RCpZmR, RCmZmR, RCpZpR, RCmYpR, RCpYmR, RCmYmR, RCpYpR});
            SEL_CH11:  return 16'({OPEROR, VNFLSH, KYRLS, TMPOUT, UPLACT, COMACT, ISSWAR});
            SEL_CH12:  return 16'({CH1214, CH1213, CH1212, CH1211, CH1210, CH1209, CH1208, CH1207,
                                   ENERIM, ZIMCDU, COARSE, STARON, ENEROP, ZOPCDU});
            SEL_NAMED: return 16'({S4BOFF, S4BSEQ, MROLGT, DISDAC, ZEROPT, S4BTAK, TVCNAB,
                                   OT1207, OT1207_});
            SEL_CHOR:  return 16'({CHOR08_, CHOR07_, CHOR06_, CHOR05_, CHOR04_, CHOR03_, CHOR02_, CHOR01_});
            SEL_STRB:  return 16'({RCH05_, WCH05_, CCH05, RCH06_, WCH06_, CCH06, RCH12_, WCH12_, CCH12});
            default:   return 16'hDEAD;
        endcase
    endfunction

    // Monitor: drains every queued expectation against the outputs at the falling edge
    initial begin
        exp_t        e;
        logic [15:0] act;
        forever begin
            @(negedge CLOCK);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = observe(e.sel);
                checks++;
                if (act !== e.expv) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.expv);
                end
            end
        end
    end

    task automatic expect_v(input int sel, input logic [15:0] v, input string name);
        exp_t e;
        e.sel = sel;
        e.expv = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle();
        XT0_ = 1; XT1_ = 1; XB2_ = 1; XB5_ = 1; XB6_ = 1;
        WCHG_ = 1; CCHG_ = 1; WCH11_ = 1; RCH11_ = 1; CCH11 = 0;
        chwl_n = 14'h3FFF; GOJAM = 0; FLASH = 0; FLASH_ = 1;
        CH0705 = 0; CH0706 = 0; CH0707 = 0;
        CH1501 = 0; CH1502 = 0; CH1503 = 0; CH1504 = 0;
        ch32 = 8'h00;
    endtask

    // Strobe vector order: {RCH05_,WCH05_,CCH05,RCH06_,WCH06_,CCH06,RCH12_,WCH12_,CCH12}
    localparam logic [15:0] STRB_IDLE = 16'(9'b110_110_110);

    initial begin
        int waited;
        CGA16 = 1;
        idle();
        rst = 1;
        tick();
        expect_v(SEL_JET05, 16'h0000, "reset_jet05");
        expect_v(SEL_JET06, 16'h0000, "reset_jet06");
        expect_v(SEL_CH11,  16'h0000, "reset_ch11");
        expect_v(SEL_CH12,  16'h0000, "reset_ch12");
        expect_v(SEL_NAMED, 16'h0001, "reset_named_ot1207n");
        expect_v(SEL_CHOR,  16'h00FF, "reset_chor");
        expect_v(SEL_STRB,  STRB_IDLE, "reset_strobes");
        rst = 0;
        tick();

        // Channel 05 write of A5
        XT0_ = 0; XB5_ = 0; WCHG_ = 0; chwl_n = ~14'h00A5;
        expect_v(SEL_STRB, 16'(9'b000_110_110), "ch05_write_strobes");
        expect_v(SEL_CHOR, 16'h00FF, "ch05_chor_before_edge");
        tick();
        expect_v(SEL_JET05, 16'h00A5, "ch05_jets");
        WCHG_ = 1; chwl_n = 14'h3FFF;
        expect_v(SEL_STRB, 16'(9'b010_110_110), "ch05_read_strobes");
        expect_v(SEL_CHOR, 16'h005A, "ch05_readback");
        tick();
        XT0_ = 1; XB5_ = 1;
        expect_v(SEL_CHOR, 16'h00FF, "ch05_deselected_chor");
        expect_v(SEL_JET05, 16'h00A5, "ch05_hold");

        // Channel 06 write of 3C
        XT0_ = 0; XB6_ = 0; WCHG_ = 0; chwl_n = ~14'h003C;
        expect_v(SEL_STRB, 16'(9'b110_000_110), "ch06_write_strobes");
        tick();
        WCHG_ = 1; chwl_n = 14'h3FFF;
        expect_v(SEL_JET06, 16'h003C, "ch06_jets");
        expect_v(SEL_CHOR, 16'h00C3, "ch06_readback");
        tick();
        XT0_ = 1; XB6_ = 1;

        // Channel 12 write of all ones, then clear
        XT1_ = 0; XB2_ = 0; WCHG_ = 0; chwl_n = 14'h0000;
        tick();
        WCHG_ = 1; CCHG_ = 0; chwl_n = 14'h3FFF;
        expect_v(SEL_CH12, 16'h3FFF, "ch12_all_ones");
        expect_v(SEL_NAMED, 16'h01FE, "ch12_named_ones");
        expect_v(SEL_STRB, 16'(9'b110_110_011), "ch12_clear_strobes");
        expect_v(SEL_CHOR, 16'h0000, "ch12_readback_ones");
        tick();
        expect_v(SEL_CH12, 16'h0000, "ch12_cleared");
        expect_v(SEL_NAMED, 16'h0001, "ch12_named_cleared");

        // Write wins over simultaneous clear; bits 9-14 do not reach CHOR
        WCHG_ = 0; CCHG_ = 0; chwl_n = ~14'h1234;
        tick();
        WCHG_ = 1; CCHG_ = 1; chwl_n = 14'h3FFF;
        expect_v(SEL_CH12, 16'h1234, "ch12_write_beats_clear");
        expect_v(SEL_CHOR, 16'h00CB, "ch12_readback_low_byte");
        tick();
        XT1_ = 1; XB2_ = 1;

        // Channel 11 lamps with flash phases
        WCH11_ = 0; chwl_n = ~14'h0070; FLASH = 1; FLASH_ = 0;
        tick();
        WCH11_ = 1; chwl_n = 14'h3FFF;
        expect_v(SEL_CH11, 16'h0050, "ch11_flash_on");
        tick();
        FLASH = 0; FLASH_ = 1; RCH11_ = 0;
        expect_v(SEL_CH11, 16'h0020, "ch11_flash_off");
        expect_v(SEL_CHOR, 16'h008F, "ch11_readback");
        tick();
        RCH11_ = 1; CCH11 = 1;
        tick();
        CCH11 = 0;
        expect_v(SEL_CH11, 16'h0000, "ch11_cleared");
        WCH11_ = 0; chwl_n = ~14'h000F;
        tick();
        WCH11_ = 1; chwl_n = 14'h3FFF;
        expect_v(SEL_CH11, 16'h000F, "ch11_direct_bits");
        expect_v(SEL_JET05, 16'h00A5, "pre_gojam_jet05");
        expect_v(SEL_CH12, 16'h1234, "pre_gojam_ch12");

        // GOJAM clears everything and overrides a concurrent ch05 write
        GOJAM = 1; XT0_ = 0; XB5_ = 0; WCHG_ = 0; chwl_n = ~14'h00FF;
        tick();
        GOJAM = 0; XT0_ = 1; XB5_ = 1; WCHG_ = 1; chwl_n = 14'h3FFF;
        expect_v(SEL_JET05, 16'h0000, "gojam_jet05");
        expect_v(SEL_JET06, 16'h0000, "gojam_jet06");
        expect_v(SEL_CH11,  16'h0000, "gojam_ch11");
        expect_v(SEL_CH12,  16'h0000, "gojam_ch12");
        expect_v(SEL_NAMED, 16'h0001, "gojam_named");

        // rst beats a channel 06 write, then the same write lands
        rst = 1; XT0_ = 0; XB6_ = 0; WCHG_ = 0; chwl_n = ~14'h0099;
        tick();
        rst = 0;
        expect_v(SEL_JET06, 16'h0000, "rst_beats_write");
        tick();
        XT0_ = 1; XB6_ = 1; WCHG_ = 1; chwl_n = 14'h3FFF;
        expect_v(SEL_JET06, 16'h0099, "ch06_after_rst");

        // Pass-through sources with no read strobe active
        CH1503 = 1;
        expect_v(SEL_CHOR, 16'h00FB, "pass_ch1503");
        tick();
        CH1503 = 0; CH0706 = 1;
        expect_v(SEL_CHOR, 16'h00DF, "pass_ch0706");
        tick();
        CH0706 = 0; ch32 = 8'h80;
        expect_v(SEL_CHOR, 16'h007F, "pass_ch3208");
        tick();
        ch32 = 8'h01; CH0705 = 1; CH1502 = 1;
        expect_v(SEL_CHOR, 16'h00EC, "pass_mixed");
        tick();
        idle();
        tick();

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            tick();
            waited++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending %0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/a16_inout_vi.md
Name: a16_inout_vi

Overview:
- AGC Block II inout module VI: holds output channels 05 and 06 (RCS jet commands), 11 bits 1-7 (DSKY/status lamps) and 12 bits 1-14 (IMU/optics/TVC/S-IVB discretes).
- Decodes channel strobes for 05, 06 and 12 from XT/XB address lines.
- Drives the active-low channel read bus CHOR01_..CHOR08_.
- Pure synchronous rendering of the original gate logic: one clock domain, all registers update on CLOCK rising edge.

Parameters:
- none

Ports:
- CLOCK  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- XT0_, XT1_, XB2_, XB5_, XB6_  in  1 each  active-low channel address decode lines
- WCHG_, CCHG_  in  1 each  active-low generic channel write / clear strobes
- WCH11_, RCH11_  in  1 each  active-low channel 11 write / read strobes
- CCH11  in  1  active-high channel 11 clear
- CHWL01_..CHWL14_  in  1 each  active-low channel write data bits 1-14
- GOJAM  in  1  active-high restart; clears all registers
- FLASH, FLASH_  in  1 each  lamp flash phase and its complement
- CH0705..CH0707, CH1501..CH1504, CH3201..CH3208  in  1 each  already read-gated active-high data from channels 07, 15, 32
- CGA16  in  1  module-present marker; no logic function
- RCH05_, WCH05_, RCH06_, WCH06_, RCH12_, WCH12_  out  1 each  decoded active-low strobes
- CCH05, CCH06, CCH12  out  1 each  decoded active-high clears
- CHOR01_..CHOR08_  out  1 each  active-low read bus bits 1-8
- RCpXpP, RCmXmP, RCpXmP, RCmXpP, RCpXpY, RCmXmY, RCpXmY, RCmXpY  out  1 each  channel 05 bits 1-8
- RCpYpR, RCmYmR, RCpYmR, RCmYpR, RCpZpR, RCmZmR, RCpZmR, RCmZpR  out  1 each  channel 06 bits 1-8
- ISSWAR, COMACT, UPLACT, TMPOUT, KYRLS, VNFLSH, OPEROR  out  1 each  channel 11 bits 1-7
- ZOPCDU, ENEROP, STARON, COARSE, ZIMCDU, ENERIM  out  1 each  channel 12 bits 1-6
- CH1207, OT1207, OT1207_  out  1 each  channel 12 bit 7, buffered copy, complement
- CH1208..CH1214  out  1 each  channel 12 bits 8-14
- TVCNAB, S4BTAK, ZEROPT, DISDAC, MROLGT, S4BSEQ, S4BOFF  out  1 each  named copies of channel 12 bits 8-14

Behaviour:
- Decode is combinational:
  - A05 = !XT0_ & !XB5_
  - A06 = !XT0_ & !XB6_
  - A12 = !XT1_ & !XB2_
- Strobes per channel n in {05, 06, 12}:
  - RCHn_ = !An
  - WCHn_ = !(An & !WCHG_)
  - CCHn = An & !CCHG_
- Registers: ch05[8:1], ch06[8:1], ch11[7:1], ch12[14:1]. Channel 11 uses its own WCH11_/CCH11 strobes. Each register updates per clock edge:
  - rst or GOJAM: 0
  - else write active: ~CHWL_ bits (write wins over a simultaneous clear)
  - else clear active: 0
  - else hold
- Outputs combinational from registers:
  - Jet, channel 12 and ISSWAR..TMPOUT outputs equal their bits directly.
  - KYRLS = ch11[5] & FLASH
  - VNFLSH = ch11[6] & FLASH_
  - OPEROR = ch11[7] & FLASH
  - OT1207 = CH1207 = ch12[7]; OT1207_ = !ch12[7]
- Read bus, for k = 1..8: CHORk_ = !( (!RCH05_ & ch05[k]) | (!RCH06_ & ch06[k]) | (!RCH11_ & ch11[k], k≤7) | (!RCH12_ & ch12[k]) | CH15k (k≤4) | CH07k (k=5..7) | CH32k ).
- Channel 12 bits 9-14 do not appear on CHOR.
- Latency:
  - Strobes and CHOR are 0-cycle (combinational).
  - Written data appears on outputs one edge after the write strobe.
- Reset values:
  - All register-derived outputs 0; OT1207_ = 1.
  - CHOR*_ = 1 when all contributing inputs are 0.
  - Strobe outputs follow inputs combinationally.
- Reset or GOJAM mid-write: clear wins.

Decomposition:
- Shared package `agc_chan_pkg`: channel bit-index constants (jet bit positions, ch12 bit names, ch11 lamp bits) and the channel address constants 05/06/11/12.
- One sub-module, `agc_chan_reg` (width parameter; inputs write, clear, data_n; register with rst/GOJAM precedence). Instantiate it four times.

Test Plan:
- Reset: rst=1 for one edge, inputs 0 -> all jet/ch11/ch12 outputs 0, OT1207_=1, CHOR01_..08_=1.
- Channel 05 write:
  - Stimulus: XT0_=0, XB5_=0, WCHG_=0, CHWL_=~14'h00A5.
  - Response: WCH05_=0 immediately; after edge, RCpXpP=1, RCpXmP=1, RCmXmY=1, RCmXpY=1, others 0.
  - Then WCHG_=1 -> RCH05_=0 and CHOR_ = ~8'hA5.
- Channel 12 write of 14'h3FFF via XT1_=0, XB2_=0 -> after edge all ch12 outputs 1, OT1207_=0; CCHG_=0 next cycle -> CCH12=1, all cleared.
- Channel 11 write of 7'h70 via WCH11_=0:
  - FLASH=1 -> KYRLS=1, OPEROR=1, VNFLSH=0.
  - FLASH=0/FLASH_=1 -> VNFLSH=1, others 0.
- GOJAM=1 with ch05/06/11/12 nonzero -> all cleared next edge; simultaneous WCH05_ write ignored.
- Pass-through inputs with no read strobe:
  - CH1503=1 -> CHOR03_=0.
  - CH0706=1 -> CHOR06_=0.
  - CH3208=1 -> CHOR08_=0.
